// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory responder: load/store funct3
// encodings, enable bit positions, FSM state codes, the latched request
// record and the store lane helpers.
package data_memory_pkg;

    // Enable bit positions inside the READ / WRITE request buses
    localparam int LOAD_EN_BIT  = 3;
    localparam int STORE_EN_BIT = 2;

    // Load funct3 encodings (READ[2:0])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3[1:0] encodings (WRITE[1:0])
    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Request captured in IDLE and held for the whole access
    typedef struct packed {
        logic        is_load;
        logic        is_store;
        logic [2:0]  load_f3;
        logic [1:0]  store_f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Byte lanes touched by a store; half/word stores align down
    function automatic logic [3:0] store_byte_en(input logic [1:0] f3,
                                                 input logic [1:0] byte_off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3)
            F3_SB:   be = 4'b0001 << byte_off;
            F3_SH:   be = byte_off[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicates the right-aligned store data onto every lane it may land in
    function automatic logic [31:0] store_lanes(input logic [1:0]  f3,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        lanes = wdata;
        case (f3)
            F3_SB:   lanes = {4{wdata[7:0]}};
            F3_SH:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_memory_load_formatter.sv
// Combinational load formatter: picks the addressed byte or halfword out of
// a memory word and sign- or zero-extends it according to the load funct3.
module data_memory_load_formatter
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection and extension; reserved funct3 codes return the word
    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves it unassigned and infers a latch.
        sel_byte = word[8*byte_off +: 8];
        sel_half = byte_off[1] ? word[31:16] : word[15:0];
        result   = word;
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LW:   result = word;
            F3_LBU:  result = {24'h000000, sel_byte};
            F3_LHU:  result = {16'h0000, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Data-memory responder for the memory-access stage. A request seen in IDLE
// is latched, BUSYWAIT stalls the core for LATENCY cycles, the access is
// performed on the last busy edge and the ACK cycle lets the core advance.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_WRITE,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    output logic [31:0] DATA_READ,
    output logic        BUSYWAIT
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_dec;
    mem_req_t         req_q, req_d;
    logic [31:0]      data_read_q, data_read_d;

    mem_req_t         new_req;
    mem_req_t         acc_req;
    logic             req_present;
    logic             do_access;
    logic             busywait;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      load_result;
    logic [3:0]       byte_en;
    logic [31:0]      wr_lanes;
    logic             mem_we;
    logic             unused_addr_hi;

    // Request as presented by the core this cycle
    assign req_present = READ[LOAD_EN_BIT] | WRITE[STORE_EN_BIT];
    assign new_req = '{
        is_load:  READ[LOAD_EN_BIT],
        is_store: WRITE[STORE_EN_BIT],
        load_f3:  READ[2:0],
        store_f3: WRITE[1:0],
        addr:     ADDR,
        wdata:    DATA_WRITE
    };

    // Only the single-cycle configuration accesses straight from IDLE
    assign acc_req = (state_q == ST_IDLE) ? new_req : req_q;

    assign cnt_dec = cnt_q - 1'b1;

    // Next-state, counter and request capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        busywait  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_present) begin
                    busywait = 1'b1;
                    req_d    = new_req;
                    cnt_d    = CNT_LOAD;
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_d   = ST_ACK;
                    end else begin
                        state_d   = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                busywait = 1'b1;
                cnt_d    = cnt_dec;
                if (cnt_dec == '0) begin
                    do_access = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSYWAIT = busywait;

    // FSM, counter and latched request registers
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Word addressing wraps; bits above the array are deliberately dropped
    assign word_idx       = acc_req.addr[IDX_W+1:2];
    assign unused_addr_hi = ^acc_req.addr[31:IDX_W+2];

    // Store lane enables and replicated write data; store wins over load
    assign byte_en  = store_byte_en(acc_req.store_f3, acc_req.addr[1:0]);
    assign wr_lanes = store_lanes(acc_req.store_f3, acc_req.wdata);
    assign mem_we   = do_access & acc_req.is_store & RST;

    // Byte-lane writes into the storage array
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset; clearing it would turn RAM into a flop bank, so only the control path resets.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];

    data_memory_load_formatter u_load_formatter (
        .word     (rd_word),
        .byte_off (acc_req.addr[1:0]),
        .funct3   (acc_req.load_f3),
        .result   (load_result)
    );

    // Load result is captured only when a pure load completes
    always_comb begin
        data_read_d = data_read_q;
        if (do_access && acc_req.is_load && !acc_req.is_store) begin
            data_read_d = load_result;
        end
    end

    // Registered load result
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_read_q <= '0;
        end else begin
            data_read_q <= data_read_d;
        end
    end

    assign DATA_READ = data_read_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: a core model issues load/store
// requests, counts BUSYWAIT cycles and compares DATA_READ against a
// byte-addressed reference memory.
module tb_data_memory;

    localparam int DEPTH     = 256;
    localparam int LAT       = 4;
    localparam int MEM_BYTES = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rd_en;
    logic [2:0]  wr_en;
    logic [31:0] dread;
    logic        busy;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [7:0]  model_mem [MEM_BYTES];
    logic [31:0] exp_dread;

    data_memory #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .ADDR       (addr),
        .DATA_WRITE (wdata),
        .READ       (rd_en),
        .WRITE      (wr_en),
        .DATA_READ  (dread),
        .BUSYWAIT   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned wrap(input logic [31:0] a);
        return int'(a) & (MEM_BYTES - 1);
    endfunction

    // Reference store: right-aligned data, half/word aligned down
    function automatic void model_store(input logic [31:0] a, input logic [1:0] f3,
                                        input logic [31:0] wd);
        int unsigned b;
        b = wrap(a);
        if (f3 == 2'd0) begin
            model_mem[b] = wd[7:0];
        end else if (f3 == 2'd1) begin
            b = b & ~32'd1;
            model_mem[b]     = wd[7:0];
            model_mem[b + 1] = wd[15:8];
        end else begin
            b = b & ~32'd3;
            for (int i = 0; i < 4; i++) model_mem[b + i] = wd[8*i +: 8];
        end
    endfunction

    // Reference load: byte/half selected by address, extended by funct3
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned b, h, w;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] wd;
        b  = wrap(a);
        h  = b & ~32'd1;
        w  = b & ~32'd3;
        by = model_mem[b];
        hw = {model_mem[h + 1], model_mem[h]};
        wd = {model_mem[w + 3], model_mem[w + 2], model_mem[w + 1], model_mem[w]};
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'h0, by};
            3'b101:  return {16'h0, hw};
            default: return wd;
        endcase
    endfunction

    // One access from the core's point of view; called just after a rising edge
    task automatic do_req(input bit ld, input bit st, input logic [2:0] ld_f3,
                          input logic [1:0] st_f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int hi;
        bit acked;
        hi    = 0;
        acked = 1'b0;
        addr  = a;
        wdata = wd;
        rd_en = {ld, ld_f3};
        wr_en = {st, st_f3};
        if (st) model_store(a, st_f3, wd);
        else if (ld) exp_dread = model_load(a, ld_f3);
        for (int i = 0; i < 16 && !acked; i++) begin
            @(negedge clk);
            if (busy) hi++;
            else acked = 1'b1;
        end
        check({tag, "_busy_cycles"}, hi, LAT);
        check({tag, "_data_read"}, dread, exp_dread);
        @(posedge clk);
        #1;
        rd_en = '0;
        wr_en = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          c0;
        int          op;
        logic [31:0] ra;
        n_checks  = 0;
        n_fail    = 0;
        exp_dread = '0;
        rst   = 1'b0;
        addr  = '0;
        wdata = '0;
        rd_en = '0;
        wr_en = '0;

        // Reset values, and BUSYWAIT following a request combinationally
        #12;
        check("rst_busywait", {31'b0, busy}, 32'd0);
        check("rst_data_read", dread, 32'd0);
        rd_en = 4'b1010;
        #1;
        check("rst_busywait_req", {31'b0, busy}, 32'd1);
        rd_en = '0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Known contents everywhere
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b1, 3'b010, 2'b10, 32'(i * 4), 32'h0, "init");

        // Word store/load
        do_req(1'b0, 1'b1, 3'b010, 2'b10, 32'h10, 32'hDEADBEEF, "sw_10");
        do_req(1'b1, 1'b0, 3'b010, 2'b10, 32'h10, 32'h0, "lw_10");
        check("lw_10_const", dread, 32'hDEADBEEF);

        // Byte store into the top lane, then signed/unsigned byte loads
        do_req(1'b0, 1'b1, 3'b000, 2'b00, 32'h13, 32'h80, "sb_13");
        do_req(1'b1, 1'b0, 3'b000, 2'b00, 32'h13, 32'h0, "lb_13");
        check("lb_13_const", dread, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 3'b100, 2'b00, 32'h13, 32'h0, "lbu_13");
        check("lbu_13_const", dread, 32'h00000080);
        do_req(1'b1, 1'b0, 3'b010, 2'b00, 32'h10, 32'h0, "lw_10b");
        check("lw_10b_const", dread, 32'h80ADBEEF);

        // Halfword store, misaligned halfword load aligns down
        do_req(1'b0, 1'b1, 3'b001, 2'b01, 32'h22, 32'h8001, "sh_22");
        do_req(1'b1, 1'b0, 3'b001, 2'b01, 32'h22, 32'h0, "lh_22");
        check("lh_22_const", dread, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 3'b101, 2'b01, 32'h23, 32'h0, "lhu_23");
        check("lhu_23_const", dread, 32'h00008001);
        do_req(1'b1, 1'b0, 3'b010, 2'b01, 32'h20, 32'h0, "lw_20");
        check("lw_20_const", dread, 32'h80010000);

        // Back-to-back store then load: exactly two accesses' worth of cycles
        c0 = cyc;
        do_req(1'b0, 1'b1, 3'b010, 2'b10, 32'h30, 32'hA5A50001, "b2b_sw");
        do_req(1'b1, 1'b0, 3'b010, 2'b10, 32'h30, 32'h0, "b2b_lw");
        check("b2b_cycles", cyc - c0, 2 * (LAT + 1));
        check("b2b_lw_const", dread, 32'hA5A50001);
        do_req(1'b1, 1'b0, 3'b010, 2'b10, 32'h10, 32'h0, "b2b_ld1");
        do_req(1'b1, 1'b0, 3'b001, 2'b10, 32'h22, 32'h0, "b2b_ld2");

        // Reset in the second busy cycle aborts the store
        addr  = 32'h40;
        wdata = 32'h12345678;
        wr_en = 3'b110;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        wr_en = '0;
        #1;
        check("abort_busywait", {31'b0, busy}, 32'd0);
        check("abort_data_read", dread, 32'd0);
        exp_dread = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 3'b010, 2'b10, 32'h40, 32'h0, "abort_lw_40");
        check("abort_lw_40_const", dread, 32'h0);

        // Store and load together: store wins, DATA_READ holds
        held = dread;
        do_req(1'b1, 1'b1, 3'b010, 2'b10, 32'h0, 32'h55, "both_sw_0");
        check("both_hold", dread, held);
        do_req(1'b1, 1'b0, 3'b010, 2'b10, 32'h0, 32'h0, "both_lw_0");
        check("both_lw_0_const", dread, 32'h55);

        // Address wrap onto word 0
        do_req(1'b0, 1'b1, 3'b010, 2'b10, 32'h400, 32'hCAFEF00D, "alias_sw");
        do_req(1'b1, 1'b0, 3'b010, 2'b10, 32'h0, 32'h0, "alias_lw");
        check("alias_lw_const", dread, 32'hCAFEF00D);

        // Randomized mix of loads, stores and combined requests
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            ra = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            if (op < 4)
                do_req(1'b0, 1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), ra, $urandom, "rnd_st");
            else if (op < 9)
                do_req(1'b1, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), ra, $urandom, "rnd_ld");
            else
                do_req(1'b1, 1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), ra, $urandom, "rnd_both");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("rnd_idle_busywait", {31'b0, busy}, 32'd0);
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
